// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga execute-stage multiply/divide unit.
// Holds the RV32M op encoding, the MDU FSM states and divider sizing.
package tartaruga_pkg;

  localparam int MDU_XLEN      = 32;
  localparam int MDU_DIV_BITS  = 1;
  localparam int MDU_DIV_ITERS = MDU_XLEN / MDU_DIV_BITS;

  // RV32M funct3 order
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic int mdu_div_iters(input int xlen, input int bits);
    return xlen / bits;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring unsigned divider, DIV_BITS quotient bits per cycle.
// Ports: clk_i/rst_i, kill_i, start_i + a_i/b_i magnitudes, last_o, q_o, r_o.
module mdu_div_iter
  import tartaruga_pkg::*;
#(
  parameter int XLEN     = MDU_XLEN,
  parameter int DIV_BITS = MDU_DIV_BITS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);

  localparam int ITERS = mdu_div_iters(XLEN, DIV_BITS);
  localparam int CW    = $clog2(ITERS);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_n, quo_n;
  logic [XLEN:0]   sh;
  logic [CW-1:0]   cnt_q;
  logic            act_q;

  // Remainder stays below the divisor, so the
  // shifted value fits in XLEN+1 bits.
  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    sh    = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      sh    = {rem_n, quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (sh >= {1'b0, dvs_q}) begin
        sh       = sh - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
      rem_n = sh[XLEN-1:0];
    end
  end

  assign last_o = act_q && (cnt_q == CW'(ITERS-1));
  assign q_o    = quo_q;
  assign r_o    = rem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (kill_i) begin
      act_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= a_i;
      dvs_q <= b_i;
      cnt_q <= '0;
      act_q <= 1'b1;
    end else if (act_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + 1'b1;
      if (last_o) act_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// RV32M multiply/divide unit: valid/ready request in, tagged result out.
// Ports: req_* handshake + operands/tag, kill_i flush, resp_* handshake, busy_o.
module exe_muldiv
  import tartaruga_pkg::*;
#(
  parameter int XLEN       = MDU_XLEN,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = MDU_DIV_BITS,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o
  ,output logic            busy_o
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]      cnt_q;

  logic accept, rq_div, rq_sgn, rq_rem;
  logic dz, ovf, special, div_start, div_last;
  logic [XLEN-1:0] spec_res, a_mag, b_mag;
  logic [XLEN-1:0] div_q, div_r;

  // Request decode: bit2 = divide, bit1 = rem, bit0 = unsigned
  assign accept  = req_valid_i & req_ready_o & ~kill_i;
  assign rq_div  = req_op_i[2];
  assign rq_rem  = req_op_i[1];
  assign rq_sgn  = ~req_op_i[0];
  assign dz      = (req_rs2_i == '0);
  assign ovf     = rq_sgn & (req_rs1_i == MIN_INT)
                 & (req_rs2_i == '1);
  assign special = rq_div & (dz | ovf);

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      dz & rq_rem:   spec_res = req_rs1_i;
      dz & ~rq_rem:  spec_res = '1;
      ~dz & rq_rem:  spec_res = '0;
      default:       spec_res = MIN_INT;
    endcase
  end

  assign a_mag = (rq_sgn & req_rs1_i[XLEN-1])
               ? -req_rs1_i : req_rs1_i;
  assign b_mag = (rq_sgn & req_rs2_i[XLEN-1])
               ? -req_rs2_i : req_rs2_i;
  assign div_start = accept & rq_div & ~special;

  mdu_div_iter #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .kill_i  (kill_i),
    .start_i (div_start),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .last_o  (div_last),
    .q_o     (div_q),
    .r_o     (div_r)
  );

  // Low 2*XLEN bits of the product of sign-extended
  // operands are exact in two's complement.
  logic            ma_s, mb_s;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0] mul_res;

  assign ma_s = (op_q == MDU_MULH) | (op_q == MDU_MULHSU);
  assign mb_s = (op_q == MDU_MULH);
  assign ma   = {{XLEN{ma_s & rs1_q[XLEN-1]}}, rs1_q};
  assign mb   = {{XLEN{mb_s & rs2_q[XLEN-1]}}, rs2_q};
  assign prod = ma * mb;

  always_comb begin
    mul_res = '0;
    unique case (op_q)
      MDU_MUL:    mul_res = prod[XLEN-1:0];
      MDU_MULH,
      MDU_MULHSU,
      MDU_MULHU:  mul_res = prod[2*XLEN-1:XLEN];
      default:    mul_res = '0;
    endcase
  end

  logic f_sgn, neg_q, neg_r;
  logic [XLEN-1:0] fix_res;

  assign f_sgn = ~op_q[0];
  assign neg_q = f_sgn & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
  assign neg_r = f_sgn & rs1_q[XLEN-1];
  assign fix_res = op_q[1]
                 ? (neg_r ? -div_r : div_r)
                 : (neg_q ? -div_q : div_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept) begin
          if (!rq_div)      state_d = ST_MUL;
          else if (special) state_d = ST_DONE;
          else              state_d = ST_DIV;
        end
      ST_MUL:
        if (cnt_q == 3'(MUL_STAGES-1)) state_d = ST_DONE;
      ST_DIV:
        if (div_last) state_d = ST_FIX;
      ST_FIX:
        state_d = ST_DONE;
      ST_DONE:
        if (resp_ready_i) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (kill_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= MDU_MUL;
      rs1_q <= '0;
      rs2_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= mdu_op_t'(req_op_i);
        rs1_q <= req_rs1_i;
        rs2_q <= req_rs2_i;
        tag_q <= req_tag_i;
        cnt_q <= '0;
        if (special) res_q <= spec_res;
      end
      if (state_q == ST_MUL) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == 3'(MUL_STAGES-1)) res_q <= mul_res;
      end
      if (state_q == ST_FIX) res_q <= fix_res;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign resp_valid_o = (state_q == ST_DONE);
  assign resp_data_o  = res_q;
  assign resp_tag_o   = tag_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed scoreboard bench for exe_muldiv (XLEN=32, MUL_STAGES=2,
// DIV_BITS=1, TAG_W=5).
module tb_exe_muldiv;
  import tartaruga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_tag;
  logic        kill;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exe_muldiv #(
    .XLEN(32), .MUL_STAGES(2), .DIV_BITS(1), .TAG_W(5)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .req_tag_i    (req_tag),
    .kill_i       (kill),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_tag_o   (resp_tag),
    .busy_o       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after accept edge.
  task automatic issue(input mdu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] e, input int lat,
                       input bit push);
    exp_t x;
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = t;
    if (push) begin
      x.d = e; x.t = t; x.lat = lat;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Waits for resp_valid, then compares against scoreboard head.
  task automatic wait_resp(input string tag);
    exp_t x;
    int   n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (resp_valid) break;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_lat"}, 32'(n), 32'(x.lat));
      chk({tag, "_data"}, resp_data, x.d);
      chk({tag, "_tag"}, 32'(resp_tag), 32'(x.t));
    end
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic run(input string tag, input mdu_op_t op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] t, input logic [31:0] e,
                     input int lat);
    issue(op, a, b, t, e, lat, 1'b1);
    wait_resp(tag);
    consume(tag);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_tag    = '0;
    kill       = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_tag", 32'(resp_tag), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("mulh_min", MDU_MULH, 32'h8000_0000, 32'h8000_0000,
        5'd7, 32'h4000_0000, 2);
    run("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
        5'd1, 32'hFFFF_FFFD, 33);
    run("rem_neg", MDU_REM, 32'hFFFF_FFF9, 32'd2,
        5'd2, 32'hFFFF_FFFF, 33);
    run("divu_z", MDU_DIVU, 32'd5, 32'd0,
        5'd3, 32'hFFFF_FFFF, 1);
    run("rem_z", MDU_REM, 32'd5, 32'd0,
        5'd4, 32'd5, 1);
    run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        5'd5, 32'h8000_0000, 1);
    run("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF,
        5'd6, 32'd0, 1);
    run("mul_neg", MDU_MUL, 32'hFFFF_FFFD, 32'd5,
        5'd8, 32'hFFFF_FFF1, 2);
    run("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,
        5'd9, 32'hFFFF_FFFF, 2);
    run("div_sd", MDU_DIV, 32'd20, 32'hFFFF_FFFD,
        5'd10, 32'hFFFF_FFFA, 33);
    run("rem_sd", MDU_REM, 32'd20, 32'hFFFF_FFFD,
        5'd11, 32'd2, 33);

    // Back-pressure: result must hold while consumer stalls
    issue(MDU_MUL, 32'd6, 32'd7, 5'd12, 32'd42, 2, 1'b1);
    wait_resp("bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", resp_data, 32'd42);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    consume("bp");

    // Kill on cycle 10 of a divide
    issue(MDU_DIV, 32'd100, 32'd7, 5'd13, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_ready", 32'(req_ready), 32'd1);
    chk("kill_valid", 32'(resp_valid), 32'd0);
    // Request during kill is not accepted
    kill      = 1'b1;
    req_valid = 1'b1;
    req_op    = MDU_MUL;
    @(posedge clk);
    #1;
    kill      = 1'b0;
    req_valid = 1'b0;
    chk("kill_req_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    chk("kill_noresp", 32'(seen), 32'd0);
    run("mulhu", MDU_MULHU, 32'hFFFF_FFFF, 32'd2,
        5'd14, 32'd1, 2);

    // Asynchronous reset between edges mid-divide
    issue(MDU_DIV, 32'd100, 32'd7, 5'd15, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(resp_valid), 32'd0);
    chk("arst_data", resp_data, 32'd0);
    chk("arst_tag", 32'(resp_tag), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run("divu_after", MDU_DIVU, 32'd100, 32'd7,
        5'd16, 32'd14, 33);
    run("remu_after", MDU_REMU, 32'd100, 32'd7,
        5'd17, 32'd2, 33);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
